// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: fixed M0 priority, locked bursts, M1 starvation guard.
// Define DMEM_ARB_STATS_EN to add per-port beat counters and a stall-cycle counter.
module dmem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_LOCK     = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]   m0_beats,
  output logic [31:0]   m1_beats,
  output logic [31:0]   stall_cycles,
`endif
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned BW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        r_state;
  logic [BW-1:0] r_beat_cnt;
  logic [SW-1:0] r_starve_cnt;
  logic          r_pref1;
  logic          r_m0_rvalid, r_m1_rvalid;
  logic [DW-1:0] r_m0_rdata, r_m1_rdata;

  logic w_g0, w_g1, w_acc, w_lock, w_at_max, w_starved;

  assign w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));
  assign w_at_max  = (r_beat_cnt == BW'(MAX_LOCK - 1));
  assign w_acc     = w_g0 | w_g1;
  assign w_lock    = w_g1 ? m1_lock : m0_lock;

  // r_pref1 hands the next IDLE slot to M1 after M0 has been cut off at MAX_LOCK.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (reset) begin
      unique case (r_state)
        IDLE: begin
          if (m1_req && (w_starved || r_pref1)) w_g1 = 1'b1;
          else if (m0_req)                      w_g0 = 1'b1;
          else if (m1_req)                      w_g1 = 1'b1;
        end
        OWN0:    w_g0 = m0_req;
        OWN1:    w_g1 = m1_req;
        default: ;
      endcase
    end
  end

  assign m0_gnt    = w_g0;
  assign m1_gnt    = w_g1;
  assign mem_wr_en = (w_g0 & m0_we) | (w_g1 & m1_we);
  assign mem_rd_en = (w_g0 & ~m0_we) | (w_g1 & ~m1_we);
  assign mem_addr  = w_g0 ? m0_addr  : (w_g1 ? m1_addr  : '0);
  assign mem_wdata = w_g0 ? m0_wdata : (w_g1 ? m1_wdata : '0);

  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_beat_cnt   <= '0;
      r_starve_cnt <= '0;
      r_pref1      <= 1'b0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_m0_rvalid <= w_g0 & ~m0_we;
      r_m1_rvalid <= w_g1 & ~m1_we;
      if (w_g0 && !m0_we) r_m0_rdata <= mem_rdata;
      if (w_g1 && !m1_we) r_m1_rdata <= mem_rdata;

      if (!m1_req || w_g1)  r_starve_cnt <= '0;
      else if (!w_starved)  r_starve_cnt <= r_starve_cnt + SW'(1);

      if (w_g0 && m0_lock && w_at_max && (MAX_LOCK > 1)) r_pref1 <= 1'b1;
      else if (r_state == IDLE)                           r_pref1 <= 1'b0;

      // Any non-accept cycle while owned means the owner dropped its request.
      if (w_acc) begin
        if (w_lock && !w_at_max) begin
          r_state    <= w_g0 ? OWN0 : OWN1;
          r_beat_cnt <= r_beat_cnt + BW'(1);
        end else begin
          r_state    <= IDLE;
          r_beat_cnt <= '0;
        end
      end else if (r_state != IDLE) begin
        r_state    <= IDLE;
        r_beat_cnt <= '0;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_m0_beats, r_m1_beats, r_stall_cycles;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_m0_beats     <= '0;
      r_m1_beats     <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_g0) r_m0_beats <= r_m0_beats + 32'd1;
      if (w_g1) r_m1_beats <= r_m1_beats + 32'd1;
      if ((m0_req && !w_g0) || (m1_req && !w_g1)) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign m0_beats     = r_m0_beats;
  assign m1_beats     = r_m1_beats;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: priority, starvation guard, lock limit, lock drop and mid-burst reset.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_wr_en, mem_rd_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] m0_beats, m1_beats, stall_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(8), .STARVE_LIMIT(4)) dut (
    .clock(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef DMEM_ARB_STATS_EN
    .m0_beats(m0_beats), .m1_beats(m1_beats), .stall_cycles(stall_cycles),
`endif
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory stand-in: 0x10 holds 0xDEADBEEF, every other address reads back as ~address.
  assign mem_rdata = (mem_addr == 32'h10) ? 32'hDEADBEEF : ~mem_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    tick;
    tick;

    // Reset state
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_mem_en", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    reset = 1'b1;

    // Single M0 read of 0x10
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    #1;
    chk("t1_gnt", {30'd0, m0_gnt, m1_gnt}, 32'b10);
    chk("t1_mem_en", {30'd0, mem_wr_en, mem_rd_en}, 32'b01);
    chk("t1_mem_addr", mem_addr, 32'h10);
    tick;
    m0_req = 1'b0;
    chk("t1_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    #1;
    chk("t1_idle_gnt", {30'd0, m0_gnt, m1_gnt}, 32'b00);
    chk("t1_idle_addr", mem_addr, 32'h0);
    tick;
    chk("t1_rvalid_pulse", {31'd0, m0_rvalid}, 32'd0);
    chk("t1_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // Contention: M0 writes continuously, M1 read starves 4 cycles then wins
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h11112222;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
    #1;
    chk("t2_mem_wdata", mem_wdata, 32'h11112222);
    chk("t2_mem_en", {30'd0, mem_wr_en, mem_rd_en}, 32'b10);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("t3_wait%0d_gnt", w), {30'd0, m0_gnt, m1_gnt}, 32'b10);
      tick;
      #1;
    end
    chk("t3_starve_gnt", {30'd0, m0_gnt, m1_gnt}, 32'b01);
    chk("t3_starve_addr", mem_addr, 32'h40);
    chk("t3_starve_en", {30'd0, mem_wr_en, mem_rd_en}, 32'b01);
    tick;
    m1_req = 1'b0;
    chk("t3_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    chk("t3_m1_rdata", m1_rdata, 32'hFFFFFFBF);
    #1;
    chk("t3_m0_back", {30'd0, m0_gnt, m1_gnt}, 32'b10);
    tick;
    m0_req = 1'b0; m0_we = 1'b0;
    chk("t3_write_no_rvalid", {31'd0, m0_rvalid}, 32'd0);

    // M1 locked burst of 12 writes; M0 read pending from the second beat
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
    for (int b = 0; b < 8; b++) begin
      m1_addr = 32'h100 + 32'(b * 4); m1_wdata = 32'(b);
      if (b == 1) begin
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h80;
      end
      #1;
      chk($sformatf("t4_beat%0d_gnt", b), {30'd0, m0_gnt, m1_gnt}, 32'b01);
      chk($sformatf("t4_beat%0d_wdata", b), mem_wdata, 32'(b));
      tick;
    end
    m1_addr = 32'h120; m1_wdata = 32'd8;
    #1;
    chk("t4_release_gnt", {30'd0, m0_gnt, m1_gnt}, 32'b10);
    chk("t4_release_addr", mem_addr, 32'h80);
    tick;
    m0_req = 1'b0;
    chk("t4_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("t4_m0_rdata", m0_rdata, 32'hFFFFFF7F);
    for (int b = 8; b < 12; b++) begin
      m1_addr = 32'h100 + 32'(b * 4); m1_wdata = 32'(b);
      m1_lock = (b != 11);
      #1;
      chk($sformatf("t4_beat%0d_gnt", b), {30'd0, m0_gnt, m1_gnt}, 32'b01);
      chk($sformatf("t4_beat%0d_addr", b), mem_addr, 32'h100 + 32'(b * 4));
      tick;
    end
    m1_req = 1'b0; m1_lock = 1'b0;
    chk("t4_no_rvalid", {31'd0, m1_rvalid}, 32'd0);
    #1;
    chk("t4_done_en", {30'd0, mem_wr_en, mem_rd_en}, 32'b00);

    // M1 takes lock then drops request: one dead cycle, then M0 granted
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b1; m1_addr = 32'h200;
    #1;
    chk("t5_lock_gnt", {30'd0, m0_gnt, m1_gnt}, 32'b01);
    tick;
    chk("t5_m1_rdata", m1_rdata, 32'hFFFFFDFF);
    m1_req = 1'b0; m1_lock = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h10;
    #1;
    chk("t5_own1_wait", {30'd0, m0_gnt, m1_gnt}, 32'b00);
    chk("t5_own1_en", {30'd0, mem_wr_en, mem_rd_en}, 32'b00);
    tick;
    #1;
    chk("t5_idle_gnt", {30'd0, m0_gnt, m1_gnt}, 32'b10);
    tick;
    chk("t5_m0_rdata", m0_rdata, 32'hDEADBEEF);

    // Reset asserted during an OWN0 read burst
    m0_lock = 1'b1;
    #1;
    chk("t6_first_gnt", {30'd0, m0_gnt, m1_gnt}, 32'b10);
    tick;
    chk("t6_first_rvalid", {31'd0, m0_rvalid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_gnt", {30'd0, m0_gnt, m1_gnt}, 32'b00);
    chk("t6_rst_en", {30'd0, mem_wr_en, mem_rd_en}, 32'b00);
    chk("t6_rst_addr", mem_addr, 32'h0);
    tick;
    chk("t6_rvalid_cleared", {31'd0, m0_rvalid}, 32'd0);
    chk("t6_rdata_cleared", m0_rdata, 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("t6_m0_beats", m0_beats, 32'd0);
    chk("t6_m1_beats", m1_beats, 32'd0);
    chk("t6_stall", stall_cycles, 32'd0);
`endif
    reset = 1'b1;
    m0_req = 1'b0; m0_lock = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h300;
    #1;
    chk("t6_idle_m1_gnt", {30'd0, m0_gnt, m1_gnt}, 32'b01);
    tick;
    m1_req = 1'b0;
    chk("t6_m1_rdata", m1_rdata, 32'hFFFFFCFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
